// File: rtl/unified_mem_ctrl_if.sv
// rtl/unified_mem_ctrl_if.sv - cache-side and memory-side signals of the unified miss controller
// slave = controller view; master = caches plus external memory
interface unified_mem_ctrl_if #(
  parameter int LINE_AW = 14,
  parameter int LINE_W  = 64,
  parameter int TAG_W   = 8
);
  logic               i_miss;
  logic [LINE_AW-1:0] i_line_addr;
  logic               i_fill_we;
  logic               d_miss;
  logic               d_dirty;
  logic [LINE_AW-1:0] d_line_addr;
  logic [TAG_W-1:0]   d_victim_tag;
  logic [LINE_W-1:0]  d_evict_data;
  logic               d_fill_we;
  logic [LINE_W-1:0]  fill_data;
  logic               busy;
  logic               mem_re;
  logic               mem_we;
  logic [LINE_AW-1:0] mem_addr;
  logic [LINE_W-1:0]  mem_wdata;
  logic [LINE_W-1:0]  mem_rdata;
  logic               mem_rdy;

  modport slave (
    input  i_miss, i_line_addr, d_miss, d_dirty, d_line_addr, d_victim_tag, d_evict_data,
           mem_rdata, mem_rdy,
    output i_fill_we, d_fill_we, fill_data, busy, mem_re, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output i_miss, i_line_addr, d_miss, d_dirty, d_line_addr, d_victim_tag, d_evict_data,
           mem_rdata, mem_rdy,
    input  i_fill_we, d_fill_we, fill_data, busy, mem_re, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/unified_mem_ctrl.sv
// rtl/unified_mem_ctrl.sv - I/D miss controller serialising evictions and fills onto one memory port
// UMEM_IPREFETCH_EN enables the one-line next-line instruction prefetch buffer
module unified_mem_ctrl #(
  parameter int LINE_AW = 14,
  parameter int LINE_W  = 64,
  parameter int TAG_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  unified_mem_ctrl_if.slave   bus
);

`ifdef UMEM_IPREFETCH_EN
  localparam bit PF_EN = 1'b1;
`else
  localparam bit PF_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, D_EVICT, D_FILL, I_FILL, PF_FILL} state_t;

  state_t             state_q, state_d;
  logic [LINE_AW-1:0] d_addr_q, d_addr_d, v_addr_q, v_addr_d, i_addr_q, i_addr_d;
  logic [LINE_AW-1:0] pf_addr_q, pf_addr_d, pf_next_q, pf_next_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d, fill_q, fill_d, pf_data_q, pf_data_d;
  logic               d_we_q, d_we_d, i_we_q, i_we_d;
  logic               pf_valid_q, pf_valid_d, pf_pend_q, pf_pend_d;
  logic               d_req, i_req, pf_hit;
  logic [LINE_AW-1:0] victim_addr;

  // A miss is still held high during its own fill pulse; mask it so it is not re-served.
  assign d_req       = bus.d_miss & ~d_we_q;
  assign i_req       = bus.i_miss & ~i_we_q;
  assign pf_hit      = PF_EN & pf_valid_q & (pf_addr_q == bus.i_line_addr);
  assign victim_addr = {bus.d_victim_tag, bus.d_line_addr[LINE_AW-TAG_W-1:0]};

  always_comb begin
    state_d    = state_q;
    d_addr_d   = d_addr_q;
    v_addr_d   = v_addr_q;
    i_addr_d   = i_addr_q;
    wdata_d    = wdata_q;
    fill_d     = fill_q;
    pf_addr_d  = pf_addr_q;
    pf_next_d  = pf_next_q;
    pf_data_d  = pf_data_q;
    pf_valid_d = pf_valid_q;
    pf_pend_d  = pf_pend_q;
    d_we_d     = 1'b0;
    i_we_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_req) begin
          d_addr_d = bus.d_line_addr;
          v_addr_d = victim_addr;
          wdata_d  = bus.d_evict_data;
          if (bus.d_dirty) begin
            state_d = D_EVICT;
            if (PF_EN && victim_addr == pf_addr_q) pf_valid_d = 1'b0;
          end else begin
            state_d = D_FILL;
          end
        end else if (i_req) begin
          if (pf_hit) begin
            fill_d     = pf_data_q;
            i_we_d     = 1'b1;
            pf_valid_d = 1'b0;
            pf_pend_d  = 1'b1;
            pf_next_d  = bus.i_line_addr + LINE_AW'(1);
          end else begin
            i_addr_d = bus.i_line_addr;
            state_d  = I_FILL;
          end
        end else if (pf_pend_q) begin
          pf_addr_d  = pf_next_q;
          pf_valid_d = 1'b0;
          pf_pend_d  = 1'b0;
          state_d    = PF_FILL;
        end
      end
      D_EVICT: if (bus.mem_rdy) state_d = D_FILL;
      D_FILL: if (bus.mem_rdy) begin
        fill_d  = bus.mem_rdata;
        d_we_d  = 1'b1;
        state_d = IDLE;
      end
      I_FILL: if (bus.mem_rdy) begin
        // Miss withdrawn before data arrived: drop the line, no prefetch follow-up.
        if (bus.i_miss) begin
          fill_d = bus.mem_rdata;
          i_we_d = 1'b1;
          if (PF_EN) begin
            pf_pend_d = 1'b1;
            pf_next_d = i_addr_q + LINE_AW'(1);
          end
        end
        state_d = IDLE;
      end
      PF_FILL: if (bus.mem_rdy) begin
        pf_data_d  = bus.mem_rdata;
        pf_valid_d = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      D_EVICT: bus.mem_addr = v_addr_q;
      D_FILL:  bus.mem_addr = d_addr_q;
      I_FILL:  bus.mem_addr = i_addr_q;
      PF_FILL: bus.mem_addr = pf_addr_q;
      default: bus.mem_addr = '0;
    endcase
  end

  assign bus.mem_we    = (state_q == D_EVICT);
  assign bus.mem_re    = (state_q == D_FILL) | (state_q == I_FILL) | (state_q == PF_FILL);
  assign bus.mem_wdata = wdata_q;
  assign bus.fill_data = fill_q;
  assign bus.d_fill_we = d_we_q;
  assign bus.i_fill_we = i_we_q;
  assign bus.busy      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      d_addr_q   <= '0;
      v_addr_q   <= '0;
      i_addr_q   <= '0;
      wdata_q    <= '0;
      fill_q     <= '0;
      pf_addr_q  <= '0;
      pf_next_q  <= '0;
      pf_data_q  <= '0;
      pf_valid_q <= 1'b0;
      pf_pend_q  <= 1'b0;
      d_we_q     <= 1'b0;
      i_we_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      d_addr_q   <= d_addr_d;
      v_addr_q   <= v_addr_d;
      i_addr_q   <= i_addr_d;
      wdata_q    <= wdata_d;
      fill_q     <= fill_d;
      pf_addr_q  <= pf_addr_d;
      pf_next_q  <= pf_next_d;
      pf_data_q  <= pf_data_d;
      pf_valid_q <= pf_valid_d;
      pf_pend_q  <= pf_pend_d;
      d_we_q     <= d_we_d;
      i_we_q     <= i_we_d;
    end
  end
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// tb/tb_unified_mem_ctrl.sv - directed bench for unified_mem_ctrl with a latency-programmable memory
// Prefetch expectations switch on UMEM_IPREFETCH_EN.
module tb_unified_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unified_mem_ctrl_if bus ();
  unified_mem_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int total = 0;
  int bad = 0;
  int mem_lat = 2;
  bit mem_en = 1'b1;
  int inject_req = 0;
  int inject_done = 0;
  int wait_cnt = 0;
  int d_fill_cnt = 0;
  int i_fill_cnt = 0;
  bit both_seen = 1'b0;
  logic [13:0] log_addr[$];
  logic        log_we[$];
  logic [63:0] log_wdata[$];

  function automatic logic [63:0] rdata_of(input logic [13:0] a);
    return {16'hC0DE, 20'h0, a, 14'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Memory: answers a request after mem_lat idle cycles; also monitors fill pulses.
  initial begin
    bus.mem_rdy = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (bus.d_fill_we) d_fill_cnt++;
      if (bus.i_fill_we) i_fill_cnt++;
      if (bus.mem_re && bus.mem_we) both_seen = 1'b1;
      if (bus.mem_rdy) begin
        bus.mem_rdy = 1'b0;
        wait_cnt = 0;
      end else if (inject_req != inject_done) begin
        inject_done = inject_req;
        bus.mem_rdy = 1'b1;
      end else if (bus.mem_re || bus.mem_we) begin
        if (mem_en) begin
          wait_cnt++;
          if (wait_cnt > mem_lat) begin
            log_addr.push_back(bus.mem_addr);
            log_we.push_back(bus.mem_we);
            log_wdata.push_back(bus.mem_wdata);
            bus.mem_rdata = rdata_of(bus.mem_addr);
            bus.mem_rdy = 1'b1;
          end
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic run_d(input logic [13:0] line, input bit dirty, input logic [7:0] tag,
                       input logic [63:0] data, output int lat, output logic [63:0] fd);
    bus.d_line_addr = line;
    bus.d_dirty = dirty;
    bus.d_victim_tag = tag;
    bus.d_evict_data = data;
    bus.d_miss = 1'b1;
    lat = 0;
    fd = '0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.d_fill_we) begin
        lat = k;
        fd = bus.fill_data;
        break;
      end
    end
    bus.d_miss = 1'b0;
  endtask

  task automatic run_i(input logic [13:0] line, output int lat, output logic [63:0] fd);
    bus.i_line_addr = line;
    bus.i_miss = 1'b1;
    lat = 0;
    fd = '0;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      if (bus.i_fill_we) begin
        lat = k;
        fd = bus.fill_data;
        break;
      end
    end
    bus.i_miss = 1'b0;
  endtask

  task automatic wait_idle();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 200; k++) begin
      if (!bus.busy) break;
      @(posedge clk); #1;
    end
    chk("idle", bus.busy, 1'b0);
  endtask

  int lat, lat2, n0, ed, ei, dcnt, icnt;
  logic [63:0] fd, fd2, fdd, fdi;

  initial begin
    bus.i_miss = 1'b0;
    bus.i_line_addr = '0;
    bus.d_miss = 1'b0;
    bus.d_dirty = 1'b0;
    bus.d_line_addr = '0;
    bus.d_victim_tag = '0;
    bus.d_evict_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_mem_re", bus.mem_re, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_d_fill_we", bus.d_fill_we, 1'b0);
    chk("rst_i_fill_we", bus.i_fill_we, 1'b0);
    chk("rst_fill_data", bus.fill_data, 64'h0);
    chk("rst_mem_addr", bus.mem_addr, 14'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Clean D miss, memory latency 4: d_fill_we N+2 cycles later.
    mem_lat = 4;
    n0 = log_addr.size();
    run_d(14'h0123, 1'b0, 8'h00, 64'h0, lat, fd);
    chk("clean_lat", lat, 6);
    chk("clean_data", fd, rdata_of(14'h0123));
    chk("clean_nacc", log_addr.size() - n0, 1);
    chk("clean_addr", log_addr[n0], 14'h0123);
    chk("clean_is_read", log_we[n0], 1'b0);
    wait_idle();
    chk("clean_dfill_cnt", d_fill_cnt, 1);

    // Dirty D miss: write-back to {tag, low line bits} then fill.
    mem_lat = 2;
    n0 = log_addr.size();
    run_d(14'h0040, 1'b1, 8'hAB, 64'h0123_4567_89AB_CDEF, lat, fd);
    wait_idle();
    chk("dirty_nacc", log_addr.size() - n0, 2);
    chk("dirty_ev_we", log_we[n0], 1'b1);
    chk("dirty_ev_addr", log_addr[n0], 14'h2AC0);
    chk("dirty_ev_data", log_wdata[n0], 64'h0123_4567_89AB_CDEF);
    chk("dirty_fill_we", log_we[n0+1], 1'b0);
    chk("dirty_fill_addr", log_addr[n0+1], 14'h0040);
    chk("dirty_data", fd, rdata_of(14'h0040));
    chk("dirty_dfill_cnt", d_fill_cnt, 2);

    // Simultaneous D and I miss: D served first, I request starts right after d_fill_we.
    mem_lat = 1;
    n0 = log_addr.size();
    bus.d_line_addr = 14'h0100;
    bus.d_dirty = 1'b0;
    bus.d_miss = 1'b1;
    bus.i_line_addr = 14'h0200;
    bus.i_miss = 1'b1;
    ed = 0;
    ei = 0;
    fdd = '0;
    fdi = '0;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      if (bus.d_fill_we) begin ed = k; fdd = bus.fill_data; bus.d_miss = 1'b0; end
      if (bus.i_fill_we) begin ei = k; fdi = bus.fill_data; bus.i_miss = 1'b0; end
      if (ei != 0) break;
    end
    bus.d_miss = 1'b0;
    bus.i_miss = 1'b0;
    chk("dual_d_lat", ed, 3);
    chk("dual_gap", ei - ed, 3);
    chk("dual_first_addr", log_addr[n0], 14'h0100);
    chk("dual_second_addr", log_addr[n0+1], 14'h0200);
    chk("dual_d_data", fdd, rdata_of(14'h0100));
    chk("dual_i_data", fdi, rdata_of(14'h0200));
    wait_idle();

    // Sequential I misses 0x0010, 0x0011.
    mem_lat = 2;
    run_i(14'h0010, lat, fd);
    chk("i10_lat", lat, 4);
    chk("i10_data", fd, rdata_of(14'h0010));
    wait_idle();
    n0 = log_addr.size();
    run_i(14'h0011, lat2, fd2);
    chk("i11_data", fd2, rdata_of(14'h0011));
`ifdef UMEM_IPREFETCH_EN
    chk("i11_hit_lat", lat2, 1);
    chk("i11_no_mem", log_addr.size() - n0, 0);
    wait_idle();
    chk("i11_next_pf", log_addr[n0], 14'h0012);
`else
    chk("i11_lat", lat2, 4);
    chk("i11_nacc", log_addr.size() - n0, 1);
    chk("i11_addr", log_addr[n0], 14'h0011);
    wait_idle();
`endif

    // Top line: next line wraps to 0.
    run_i(14'h3FFF, lat, fd);
    chk("i3fff_data", fd, rdata_of(14'h3FFF));
    wait_idle();
`ifdef UMEM_IPREFETCH_EN
    chk("wrap_pf_addr", log_addr[log_addr.size()-1], 14'h0000);
    chk("wrap_pf_read", log_we[log_we.size()-1], 1'b0);
`else
    chk("wrap_last_addr", log_addr[log_addr.size()-1], 14'h3FFF);
`endif

    // I miss withdrawn before data returns: no fill pulse.
    mem_en = 1'b0;
    icnt = i_fill_cnt;
    bus.i_line_addr = 14'h0055;
    bus.i_miss = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("disc_busy", bus.busy, 1'b1);
    bus.i_miss = 1'b0;
    @(negedge clk) inject_req++;
    repeat (3) @(posedge clk);
    #1;
    chk("disc_idle", bus.busy, 1'b0);
    chk("disc_no_fill", i_fill_cnt, icnt);

    // Reset during D_FILL, then a late mem_rdy.
    dcnt = d_fill_cnt;
    bus.d_line_addr = 14'h0077;
    bus.d_dirty = 1'b0;
    bus.d_miss = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_mem_re", bus.mem_re, 1'b1);
    chk("mid_mem_addr", bus.mem_addr, 14'h0077);
    @(negedge clk);
    rst_n = 1'b0;
    bus.d_miss = 1'b0;
    #1;
    chk("rst2_busy", bus.busy, 1'b0);
    chk("rst2_mem_re", bus.mem_re, 1'b0);
    chk("rst2_mem_addr", bus.mem_addr, 14'h0);
    chk("rst2_fill_data", bus.fill_data, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    inject_req++;
    repeat (4) @(posedge clk);
    #1;
    chk("late_rdy_no_fill", d_fill_cnt, dcnt);
    chk("late_rdy_idle", bus.busy, 1'b0);
    chk("late_rdy_no_req", bus.mem_re, 1'b0);
    mem_en = 1'b1;

    chk("no_re_we_overlap", both_seen, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
